// File: rtl/or1200_alarm_pkg.sv
// Shared types and constants for the OR1200 alarm response block.
package or1200_alarm_pkg;

  localparam int unsigned CHK_W   = 6;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned FILT_W  = 4;
  localparam int unsigned CNT_W   = 8;

  // Bit positions within chk_ok / syndrome
  localparam int unsigned CHK_SUPV_CONSISTENT = 0;
  localparam int unsigned CHK_DMMU_FAULT_OK   = 1;
  localparam int unsigned CHK_IMMU_FAULT_OK   = 2;
  localparam int unsigned CHK_MMUS_OK         = 3;
  localparam int unsigned CHK_PIPELINE_OK     = 4;
  localparam int unsigned CHK_SR_OK           = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_FILTER   = 3'd1,
    ST_REQ      = 3'd2,
    ST_WAIT_CLR = 3'd3,
    ST_LOCK     = 3'd4
  } alarm_state_e;

endpackage

// File: rtl/or1200_alarm_filter.sv
// Fault persistence counter: pass rises on the FILTER_CYCLES-th consecutive fault cycle.
module or1200_alarm_filter
  import or1200_alarm_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fault,
  input  logic restart,
  output logic pass
);

  logic [FILT_W-1:0] cnt_q, cnt_d;

  // Counter holds the number of fault cycles already seen; restart keeps it idle.
  always_comb begin
    cnt_d = '0;
    pass  = fault && !restart && (cnt_q == FILT_W'(FILTER_CYCLES - 1));
    if (fault && !restart && !pass) begin
      cnt_d = cnt_q + FILT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/or1200_alarm_resp.sv
// Alarm response FSM: filters checker faults, raises an exception and tracks syndromes.
// Optional lockdown state enabled by defining OR1200_ALARM_LOCKDOWN_EN.
module or1200_alarm_resp
  import or1200_alarm_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 1,
  parameter int unsigned LOCK_THRESH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CHK_W-1:0]   chk_ok,
  input  logic               supv,
  input  logic               clr,
  input  logic               except_ack,
  output logic               except_req,
  output logic [CHK_W-1:0]   syndrome,
  output logic [CHK_W-1:0]   syndrome_acc,
  output logic [CNT_W-1:0]   alarm_cnt,
  output logic               cpu_halt,
  output logic [STATE_W-1:0] state_o
);

`ifdef OR1200_ALARM_LOCKDOWN_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  alarm_state_e     state_q, state_d;
  logic             except_req_q, except_req_d;
  logic [CHK_W-1:0] syndrome_q, syndrome_d;
  logic [CHK_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
  logic             fault;
  logic             restart;
  logic             pass;

  assign fault   = ~&chk_ok;
  assign restart = (state_q != ST_IDLE) && (state_q != ST_FILTER);

  or1200_alarm_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .fault  (fault),
    .restart(restart),
    .pass   (pass)
  );

  // Next state and registered-output values
  always_comb begin
    state_d     = state_q;
    syndrome_d  = syndrome_q;
    acc_d       = acc_q | ~chk_ok;
    alarm_cnt_d = alarm_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pass) begin
          state_d = ST_REQ;
        end else if (fault) begin
          state_d = ST_FILTER;
        end
      end
      ST_FILTER: begin
        if (pass) begin
          state_d = ST_REQ;
        end else if (!fault) begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (except_ack) begin
          if (LOCK_EN && (alarm_cnt_q >= CNT_W'(LOCK_THRESH))) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_WAIT_CLR;
          end
        end
      end
      ST_WAIT_CLR: begin
        if (clr && supv) begin
          state_d    = ST_IDLE;
          syndrome_d = '0;
        end
      end
      ST_LOCK: begin
        state_d = ST_LOCK;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // pass can only assert from IDLE/FILTER, so this is exactly entry to REQ
    if (pass) begin
      syndrome_d = ~chk_ok;
      if (alarm_cnt_q != '1) begin
        alarm_cnt_d = alarm_cnt_q + CNT_W'(1);
      end
    end

    except_req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      except_req_q <= 1'b0;
      syndrome_q   <= '0;
      acc_q        <= '0;
      alarm_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      except_req_q <= except_req_d;
      syndrome_q   <= syndrome_d;
      acc_q        <= acc_d;
      alarm_cnt_q  <= alarm_cnt_d;
    end
  end

`ifdef OR1200_ALARM_LOCKDOWN_EN
  logic cpu_halt_q, cpu_halt_d;

  assign cpu_halt_d = (state_d == ST_LOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_halt_q <= 1'b0;
    end else begin
      cpu_halt_q <= cpu_halt_d;
    end
  end

  assign cpu_halt = cpu_halt_q;
`else
  assign cpu_halt = 1'b0;
`endif

  assign except_req   = except_req_q;
  assign syndrome     = syndrome_q;
  assign syndrome_acc = acc_q;
  assign alarm_cnt    = alarm_cnt_q;
  assign state_o      = STATE_W'(state_q);

endmodule

// File: tb/tb_or1200_alarm_resp.sv
// Scoreboard bench: two instances (FILTER_CYCLES 1 and 3) share stimulus and are checked per cycle.
module tb_or1200_alarm_resp;
  import or1200_alarm_pkg::*;

`ifdef OR1200_ALARM_LOCKDOWN_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam int LOCK_THR = 2;
  localparam logic [5:0] ALL_OK = 6'h3f;

  typedef struct {
    logic [2:0] st;
    int         fcnt;
    logic       ereq;
    logic [5:0] syn;
    logic [5:0] acc;
    logic [7:0] cnt;
    logic       halt;
  } mstate_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] chk_ok;
  logic       supv, clr, except_ack;

  logic       a_ereq, b_ereq, a_halt, b_halt;
  logic [5:0] a_syn, b_syn, a_acc, b_acc;
  logic [7:0] a_cnt, b_cnt;
  logic [2:0] a_st, b_st;

  int vec_cnt = 0;
  int err_cnt = 0;
  mstate_t ma, mb;
  mstate_t exp_q[$];

  or1200_alarm_resp #(.FILTER_CYCLES(1), .LOCK_THRESH(LOCK_THR)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .chk_ok(chk_ok), .supv(supv), .clr(clr),
    .except_ack(except_ack), .except_req(a_ereq), .syndrome(a_syn),
    .syndrome_acc(a_acc), .alarm_cnt(a_cnt), .cpu_halt(a_halt), .state_o(a_st)
  );

  or1200_alarm_resp #(.FILTER_CYCLES(3), .LOCK_THRESH(LOCK_THR)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .chk_ok(chk_ok), .supv(supv), .clr(clr),
    .except_ack(except_ack), .except_req(b_ereq), .syndrome(b_syn),
    .syndrome_acc(b_acc), .alarm_cnt(b_cnt), .cpu_halt(b_halt), .state_o(b_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(string tag, logic [2:0] st, logic ereq, logic [5:0] syn,
                           logic [5:0] acc, logic [7:0] cnt, logic halt, mstate_t e);
    check({tag, ".state"},    32'(st),   32'(e.st));
    check({tag, ".ereq"},     32'(ereq), 32'(e.ereq));
    check({tag, ".syndrome"}, 32'(syn),  32'(e.syn));
    check({tag, ".acc"},      32'(acc),  32'(e.acc));
    check({tag, ".cnt"},      32'(cnt),  32'(e.cnt));
    check({tag, ".halt"},     32'(halt), 32'(e.halt));
  endtask

  function automatic mstate_t mzero();
    mstate_t z;
    z.st = ST_IDLE; z.fcnt = 0; z.ereq = 1'b0; z.syn = '0;
    z.acc = '0; z.cnt = '0; z.halt = 1'b0;
    return z;
  endfunction

  // Behavioural reference of one clock edge
  function automatic mstate_t model_next(mstate_t m, int fc, logic [5:0] chk,
                                         logic s, logic c, logic ack);
    mstate_t n;
    logic    flt;
    logic    raise;
    n     = m;
    flt   = (chk != ALL_OK);
    raise = 1'b0;
    n.acc = m.acc | ~chk;
    case (m.st)
      ST_IDLE: begin
        if (flt) begin
          if (fc == 1) raise = 1'b1;
          else begin n.st = ST_FILTER; n.fcnt = 1; end
        end
      end
      ST_FILTER: begin
        if (!flt) begin n.st = ST_IDLE; n.fcnt = 0; end
        else if (m.fcnt + 1 == fc) raise = 1'b1;
        else n.fcnt = m.fcnt + 1;
      end
      ST_REQ: begin
        if (ack) n.st = (LOCK_EN && (int'(m.cnt) >= LOCK_THR)) ? ST_LOCK : ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (c && s) begin n.st = ST_IDLE; n.syn = '0; end
      end
      default: ;
    endcase
    if (raise) begin
      n.st = ST_REQ; n.fcnt = 0; n.syn = ~chk;
      if (m.cnt != 8'd255) n.cnt = m.cnt + 8'd1;
    end
    n.ereq = (n.st == ST_REQ);
    n.halt = (n.st == ST_LOCK);
    return n;
  endfunction

  task automatic step(logic [5:0] chk, logic s, logic c, logic ack);
    mstate_t ea, eb;
    chk_ok = chk; supv = s; clr = c; except_ack = ack;
    ma = model_next(ma, 1, chk, s, c, ack);
    mb = model_next(mb, 3, chk, s, c, ack);
    exp_q.push_back(ma);
    exp_q.push_back(mb);
    @(posedge clk);
    #1;
    ea = exp_q.pop_front();
    eb = exp_q.pop_front();
    check_dut("a", a_st, a_ereq, a_syn, a_acc, a_cnt, a_halt, ea);
    check_dut("b", b_st, b_ereq, b_syn, b_acc, b_cnt, b_halt, eb);
  endtask

  task automatic apply_reset(string tag);
    #2;
    rst_n = 1'b0;
    chk_ok = ALL_OK; supv = 1'b0; clr = 1'b0; except_ack = 1'b0;
    #1;
    ma = mzero();
    mb = mzero();
    exp_q.delete();
    check_dut({tag, "_a"}, a_st, a_ereq, a_syn, a_acc, a_cnt, a_halt, ma);
    check_dut({tag, "_b"}, b_st, b_ereq, b_syn, b_acc, b_cnt, b_halt, mb);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] f_dmmu, f_sr;
    f_dmmu = ALL_OK; f_dmmu[CHK_DMMU_FAULT_OK] = 1'b0;
    f_sr   = ALL_OK; f_sr[CHK_SR_OK] = 1'b0;
    rst_n = 1'b1; chk_ok = ALL_OK; supv = 1'b0; clr = 1'b0; except_ack = 1'b0;
    ma = mzero(); mb = mzero();
    apply_reset("rst");
    step(ALL_OK, 0, 0, 0);
    step(ALL_OK, 0, 0, 0);

    // Single-cycle DMMU fault raises immediately on the unfiltered instance
    step(f_dmmu, 0, 0, 0);
    check("d_ereq", 32'(a_ereq), 32'd1);
    check("d_syn",  32'(a_syn),  32'(6'b000010));
    check("d_cnt",  32'(a_cnt),  32'd1);
    step(ALL_OK, 0, 0, 0);

    // Second fault during REQ only accumulates
    step(f_sr, 0, 0, 0);
    step(ALL_OK, 0, 0, 0);
    check("d_req_syn", 32'(a_syn), 32'(6'b000010));
    check("d_req_acc", 32'(a_acc), 32'(6'b100010));
    check("d_req_cnt", 32'(a_cnt), 32'd1);

    // Ack, unprivileged clear ignored, privileged clear returns to IDLE
    step(ALL_OK, 0, 0, 1);
    check("d_ack_ereq", 32'(a_ereq), 32'd0);
    step(ALL_OK, 0, 1, 0);
    check("d_clr_user", 32'(a_st), 32'(ST_WAIT_CLR));
    step(ALL_OK, 1, 1, 0);
    check("d_clr_st",  32'(a_st),  32'(ST_IDLE));
    check("d_clr_syn", 32'(a_syn), 32'd0);
    check("d_clr_acc", 32'(a_acc), 32'(6'b100010));

    // Two-cycle fault is filtered out on the 3-cycle instance
    step(f_dmmu, 0, 0, 0);
    step(f_dmmu, 0, 0, 0);
    step(ALL_OK, 0, 0, 0);
    check("d_filt_ereq", 32'(b_ereq), 32'd0);
    check("d_filt_cnt",  32'(b_cnt),  32'd0);
    check("d_filt_acc",  32'(b_acc),  32'(6'b100010));

    // Fault on the WAIT_CLR exit cycle is evaluated from IDLE afterwards
    step(ALL_OK, 0, 0, 1);
    step(f_dmmu, 1, 1, 0);
    check("d_exit_st", 32'(a_st), 32'(ST_IDLE));
    step(f_dmmu, 0, 0, 0);
    check("d_exit_ereq", 32'(a_ereq), 32'd1);
    step(ALL_OK, 0, 0, 1);
    step(ALL_OK, 1, 1, 0);
    step(ALL_OK, 0, 0, 0);

    // Three consecutive faults raise on the 3-cycle instance at the third edge
    step(f_sr, 0, 0, 0);
    step(f_sr, 0, 0, 0);
    check("d_lat_early", 32'(b_ereq), 32'd0);
    step(f_sr, 0, 0, 0);
    check("d_lat_ereq", 32'(b_ereq), 32'd1);
    check("d_lat_syn",  32'(b_syn),  32'(6'b100000));
    step(ALL_OK, 0, 0, 1);
    step(ALL_OK, 1, 1, 0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      logic [5:0] c;
      c = ($urandom_range(0, 7) < 3) ? 6'($urandom) : ALL_OK;
      step(c, 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    // Reset while a request is outstanding
    apply_reset("rst2");
    step(f_dmmu, 0, 0, 0);
    apply_reset("rst_mid");
    step(ALL_OK, 0, 0, 0);
    check("d_mid_ereq", 32'(a_ereq), 32'd0);

`ifdef OR1200_ALARM_LOCKDOWN_EN
    step(f_dmmu, 0, 0, 0);
    step(ALL_OK, 0, 0, 1);
    step(ALL_OK, 1, 1, 0);
    step(f_dmmu, 0, 0, 0);
    step(ALL_OK, 0, 0, 1);
    check("d_lock_halt", 32'(a_halt), 32'd1);
    step(ALL_OK, 1, 1, 0);
    check("d_lock_st", 32'(a_st), 32'(ST_LOCK));
    apply_reset("rst_lock");
`else
    for (int i = 0; i < 300; i++) begin
      step(f_dmmu, 0, 0, 0);
      step(ALL_OK, 0, 0, 1);
      step(ALL_OK, 1, 1, 0);
    end
    check("d_sat_cnt",  32'(a_cnt),  32'd255);
    check("d_sat_halt", 32'(a_halt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/or1200_alarm_resp.md
OR1200_ALARM_RESP -- requirements
Module: or1200_alarm_resp

Interface
REQ-001 Parameter FILTER_CYCLES, default 1: consecutive fault cycles required before raising (range 1..15).
REQ-002 Parameter LOCK_THRESH, default 4: alarm count at which lockdown is entered (range 1..255).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 chk_ok  in  6  checker results {sr_ok, pipeline_ok, mmus_ok, immu_fault_ok, dmmu_fault_ok, supv_consistent}; 1 = pass.
REQ-006 supv  in  1  current supervisor mode; qualifies clr.
REQ-007 clr  in  1  software clear request.
REQ-008 except_ack  in  1  exception unit accepts the alarm exception.
REQ-009 except_req  out  1  alarm exception request to the exception unit.
REQ-010 syndrome  out  6  first-fault syndrome, where 1 = that check failed.
REQ-011 syndrome_acc  out  6  sticky OR of all faults since reset.
REQ-012 alarm_cnt  out  8  saturating count of raised alarms.
REQ-013 cpu_halt  out  1  lockdown halt to the CPU.
REQ-014 state_o  out  3  current FSM state, for debug.

Function
REQ-015 Fault condition: fault = ~&chk_ok.
REQ-016 The FSM states SHALL be IDLE, FILTER, REQ, WAIT_CLR and LOCK.
REQ-017 IDLE, fault:
- FILTER_CYCLES==1: go to REQ.
- Otherwise: go to FILTER with filt_cnt=1.
REQ-018 FILTER, fault still present: increment filt_cnt; on reaching FILTER_CYCLES, go to REQ.
REQ-019 FILTER, fault absent: return to IDLE; no syndrome capture, no count.
REQ-020 On entry to REQ:
- syndrome <= ~chk_ok of that cycle;
- alarm_cnt increments, saturating at 255.
REQ-021 Latency: a fault first sampled at edge t SHALL give except_req=1 after edge t+FILTER_CYCLES-1.
REQ-022 REQ: except_req held at 1 until except_ack is sampled high; except_ack is ignored while except_req=0.
REQ-023 REQ with except_ack: go to LOCK if the macro is defined and alarm_cnt>=LOCK_THRESH, else to WAIT_CLR; except_req=0 on the next cycle.
REQ-024 WAIT_CLR, clr&supv: go to IDLE and set syndrome to 0.
REQ-025 WAIT_CLR, clr&~supv: ignored; stay in WAIT_CLR.
REQ-026 Faults in REQ or WAIT_CLR SHALL NOT re-raise the alarm or alter syndrome; they OR into syndrome_acc only.
REQ-027 syndrome_acc updates every cycle in all states (acc |= ~chk_ok); it is cleared only by reset.
REQ-028 A fault present in the same cycle WAIT_CLR exits to IDLE SHALL be evaluated from IDLE on the next cycle.
REQ-029 LOCK is terminal until reset: cpu_halt=1, except_req=0, clr ignored.

Reset
REQ-030 rst_n low SHALL immediately force:
- state=IDLE, filt_cnt=0;
- except_req=0, cpu_halt=0;
- syndrome=0, syndrome_acc=0, alarm_cnt=0.
REQ-031 Reset mid-handshake (REQ or WAIT_CLR) SHALL abandon the request; no ack is required afterwards.

Configuration
REQ-032 Macro OR1200_ALARM_LOCKDOWN_EN defined: the LOCK state and cpu_halt behave per REQ-023 and REQ-029.
REQ-033 Macro undefined: LOCK is unreachable, cpu_halt is tied to 0, and LOCK_THRESH is unused.

Structure
REQ-034 Shared package or1200_alarm_pkg SHALL hold:
- state encoding constants;
- CHK_W=6;
- per-check bit-index constants.
REQ-035 Sub-module or1200_alarm_filter SHALL implement the fault persistence counter (inputs fault and restart, output pass).
REQ-036 All outputs SHALL be registered except state_o, which is a direct copy of the state register.

Verification
REQ-037 FILTER_CYCLES=1; chk_ok=6'b111101 for 1 cycle -> except_req=1 next cycle, syndrome=6'b000010, alarm_cnt=1.
REQ-038 FILTER_CYCLES=3; 2-cycle fault then pass -> except_req stays 0, alarm_cnt=0, syndrome_acc=6'b000010 (or the faulted bits).
REQ-039 After ack, in WAIT_CLR: clr=1,supv=0 -> state stays WAIT_CLR; then clr=1,supv=1 -> IDLE, syndrome=0, syndrome_acc retained.
REQ-040 During REQ, inject a second fault 6'b011111 -> syndrome unchanged, syndrome_acc gains bit 5, no second alarm_cnt increment.
REQ-041 Macro on, LOCK_THRESH=2: two alarm/ack cycles -> second ack enters LOCK, cpu_halt=1, clr ignored; rst_n low -> all outputs 0.
REQ-042 Macro off: 300 alarm/ack/clr cycles -> alarm_cnt saturates at 255, cpu_halt stays 0.
